decode_queue: RTL and testbench

Parametrised fetch-to-decode buffer for the Virgule core. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake and decodes each into an `opcodes_pkg::instruction_t`. Decoded entries are held in a DEPTH-entry FIFO and presented to the execute side over a second valid/ready handshake. A synchronous flush discards all in-flight work on a taken jump, branch or mret. It supersedes the single-word combinational decoder with configurable depth, an optional decode register stage, and an illegal-instruction flag.

---
 rtl/opcodes_pkg.sv | 42 ++++
 rtl/decode_queue.sv | 279 +++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/opcodes_pkg.sv
// Decoded-instruction types shared by the Virgule fetch/decode/execute path.
// instr_nop is the all-quiet entry presented when no instruction is available.
package opcodes_pkg;

   typedef enum logic [3:0] {
      alu_nop  = 4'd0,
      alu_add  = 4'd1,
      alu_sub  = 4'd2,
      alu_sll  = 4'd3,
      alu_slt  = 4'd4,
      alu_sltu = 4'd5,
      alu_xor  = 4'd6,
      alu_srl  = 4'd7,
      alu_sra  = 4'd8,
      alu_or   = 4'd9,
      alu_and  = 4'd10
   } alu_fn_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
      alu_fn_t     alu_fn;
      logic        use_pc;
      logic        use_imm;
      logic        has_rd;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jump;
      logic        is_mret;
   } instruction_t;

   localparam instruction_t instr_nop = '{
      rd: 5'd0, rs1: 5'd0, rs2: 5'd0, funct3: 3'd0, imm: 32'd0, alu_fn: alu_nop,
      use_pc: 1'b0, use_imm: 1'b0, has_rd: 1'b0, is_load: 1'b0, is_store: 1'b0,
      is_branch: 1'b0, is_jump: 1'b0, is_mret: 1'b0
   };

endpackage

// File: rtl/decode_queue.sv
// Fetch-to-decode buffer: RV32I decode into a DEPTH-entry FIFO, optional decode register stage.
// Optional per-entry illegal flag under DECODE_QUEUE_ILLEGAL_EN; flush/reset empty everything next edge.
module decode_queue
   import opcodes_pkg::*;
#(
   parameter int DEPTH             = 4,
   parameter int REGISTERED_DECODE = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_word,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output instruction_t             out_instr,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic alu_fn_t alu_sel(input logic [2:0] f3, input logic alt, input logic is_op);
      case (f3)
         3'b000:  alu_sel = (is_op && alt) ? alu_sub : alu_add;
         3'b001:  alu_sel = alu_sll;
         3'b010:  alu_sel = alu_slt;
         3'b011:  alu_sel = alu_sltu;
         3'b100:  alu_sel = alu_xor;
         3'b101:  alu_sel = alt ? alu_sra : alu_srl;
         3'b110:  alu_sel = alu_or;
         default: alu_sel = alu_and;
      endcase
   endfunction

   logic [6:0]   opc;
   logic [2:0]   f3;
   logic         rd_nz;
   logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
   instruction_t dec_instr;

   assign opc   = in_word[6:0];
   assign f3    = in_word[14:12];
   assign rd_nz = (in_word[11:7] != 5'd0);
   assign imm_i = {{20{in_word[31]}}, in_word[31:20]};
   assign imm_s = {{20{in_word[31]}}, in_word[31:25], in_word[11:7]};
   assign imm_b = {{19{in_word[31]}}, in_word[31], in_word[7], in_word[30:25], in_word[11:8], 1'b0};
   assign imm_u = {in_word[31:12], 12'd0};
   assign imm_j = {{11{in_word[31]}}, in_word[31], in_word[19:12], in_word[20], in_word[30:21], 1'b0};

   always_comb begin
      dec_instr        = instr_nop;
      dec_instr.rd     = in_word[11:7];
      dec_instr.rs1    = in_word[19:15];
      dec_instr.rs2    = in_word[24:20];
      dec_instr.funct3 = f3;
      case (opc)
         OPC_LOAD: begin
            dec_instr.imm     = imm_i;
            dec_instr.alu_fn  = alu_add;
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
            dec_instr.is_load = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_instr.imm     = imm_i;
            dec_instr.alu_fn  = alu_sel(f3, in_word[30], 1'b0);
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
         end
         OPC_AUIPC: begin
            dec_instr.imm     = imm_u;
            dec_instr.alu_fn  = alu_add;
            dec_instr.use_pc  = 1'b1;
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
         end
         OPC_STORE: begin
            dec_instr.imm      = imm_s;
            dec_instr.alu_fn   = alu_add;
            dec_instr.use_imm  = 1'b1;
            dec_instr.is_store = 1'b1;
         end
         OPC_OP: begin
            dec_instr.alu_fn = alu_sel(f3, in_word[30], 1'b1);
            dec_instr.has_rd = rd_nz;
         end
         OPC_LUI: begin
            dec_instr.imm     = imm_u;
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
         end
         OPC_BRANCH: begin
            dec_instr.imm       = imm_b;
            dec_instr.alu_fn    = alu_add;
            dec_instr.use_pc    = 1'b1;
            dec_instr.is_branch = 1'b1;
         end
         OPC_JALR: begin
            dec_instr.imm     = imm_i;
            dec_instr.alu_fn  = alu_add;
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
            dec_instr.is_jump = 1'b1;
         end
         OPC_JAL: begin
            dec_instr.imm     = imm_j;
            dec_instr.alu_fn  = alu_add;
            dec_instr.use_pc  = 1'b1;
            dec_instr.use_imm = 1'b1;
            dec_instr.has_rd  = rd_nz;
            dec_instr.is_jump = 1'b1;
         end
         OPC_SYSTEM: begin
            dec_instr.imm     = imm_i;
            dec_instr.use_imm = 1'b1;
            dec_instr.is_mret = (f3 == 3'b000) && (in_word[31:20] == 12'h302);
         end
         default: ;
      endcase
   end

`ifdef DECODE_QUEUE_ILLEGAL_EN
   logic       dec_illegal;
   logic [6:0] f7;
   assign f7 = in_word[31:25];

   always_comb begin
      dec_illegal = 1'b0;
      case (opc)
         OPC_OP:     dec_illegal = !((f7 == 7'h00) ||
                                     ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
         OPC_OP_IMM: begin
            if (f3 == 3'b001)      dec_illegal = (f7 != 7'h00);
            else if (f3 == 3'b101) dec_illegal = !((f7 == 7'h00) || (f7 == 7'h20));
         end
         OPC_LOAD:   dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         OPC_STORE:  dec_illegal = (f3 > 3'b010);
         OPC_BRANCH: dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
         OPC_JALR:   dec_illegal = (f3 != 3'b000);
         OPC_SYSTEM: dec_illegal = !dec_instr.is_mret;
         OPC_LUI, OPC_AUIPC, OPC_JAL: dec_illegal = 1'b0;
         default:    dec_illegal = 1'b1;
      endcase
   end
`endif

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, occ;
   logic          push, wr_en, rd_en, stg_vld;
   instruction_t  wr_instr;
   logic [31:0]   wr_pc;
`ifdef DECODE_QUEUE_ILLEGAL_EN
   logic          wr_ill;
`endif

   // The decode stage counts toward occupancy so a stalled stage never loses its entry.
   assign occ      = count_q + CW'(stg_vld);
   assign in_ready = !reset && !flush && (occ < CW'(DEPTH));
   assign push     = in_valid && in_ready;

   generate
      if (REGISTERED_DECODE != 0) begin : g_stage
         logic         vld_q, vld_d;
         instruction_t instr_q, instr_d;
         logic [31:0]  pc_q, pc_d;
         logic         fifo_full;
`ifdef DECODE_QUEUE_ILLEGAL_EN
         logic         ill_q, ill_d;
`endif
         assign fifo_full = (count_q == CW'(DEPTH));

         always_comb begin
            vld_d   = vld_q;
            instr_d = instr_q;
            pc_d    = pc_q;
`ifdef DECODE_QUEUE_ILLEGAL_EN
            ill_d   = ill_q;
`endif
            if (vld_q && !fifo_full) vld_d = 1'b0;
            if (push) begin
               vld_d   = 1'b1;
               instr_d = dec_instr;
               pc_d    = in_pc;
`ifdef DECODE_QUEUE_ILLEGAL_EN
               ill_d   = dec_illegal;
`endif
            end
         end

         always_ff @(posedge clk) begin
            if (reset || flush) vld_q <= 1'b0;
            else                vld_q <= vld_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
`ifdef DECODE_QUEUE_ILLEGAL_EN
            ill_q   <= ill_d;
`endif
         end

         assign stg_vld  = vld_q;
         assign wr_en    = vld_q && !fifo_full && !reset && !flush;
         assign wr_instr = instr_q;
         assign wr_pc    = pc_q;
`ifdef DECODE_QUEUE_ILLEGAL_EN
         assign wr_ill   = ill_q;
`endif
      end else begin : g_direct
         assign stg_vld  = 1'b0;
         assign wr_en    = push;
         assign wr_instr = dec_instr;
         assign wr_pc    = in_pc;
`ifdef DECODE_QUEUE_ILLEGAL_EN
         assign wr_ill   = dec_illegal;
`endif
      end
   endgenerate

   instruction_t mem_instr_q [DEPTH];
   logic [31:0]  mem_pc_q    [DEPTH];

   assign out_valid = (count_q != '0);
   assign rd_en     = out_valid && out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_instr_q[wr_ptr_q] <= wr_instr;
         mem_pc_q[wr_ptr_q]    <= wr_pc;
      end
   end

   assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : instr_nop;
   assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q] : 32'd0;
   assign count     = count_q;

`ifdef DECODE_QUEUE_ILLEGAL_EN
   logic mem_ill_q [DEPTH];
   always_ff @(posedge clk) begin
      if (wr_en) mem_ill_q[wr_ptr_q] <= wr_ill;
   end
   assign out_illegal = out_valid ? mem_ill_q[rd_ptr_q] : 1'b0;
`else
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, REGISTERED_DECODE=0); follows DECODE_QUEUE_ILLEGAL_EN.
module tb_decode_queue;
   import opcodes_pkg::*;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, out_ready;
   logic [31:0]  in_pc, in_word;
   logic         in_ready, out_valid, out_illegal;
   logic [31:0]  out_pc;
   instruction_t out_instr;
   logic [2:0]   count;

   int pass_cnt = 0;
   int chk_cnt  = 0;

`ifdef DECODE_QUEUE_ILLEGAL_EN
   localparam logic ILL_EN = 1'b1;
`else
   localparam logic ILL_EN = 1'b0;
`endif

   decode_queue #(.DEPTH(4), .REGISTERED_DECODE(0)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] word);
      in_valid = 1'b1; in_pc = pc; in_word = word;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   function automatic logic [7:0] flags(input instruction_t i);
      return {i.use_pc, i.use_imm, i.has_rd, i.is_load, i.is_store, i.is_branch, i.is_jump, i.is_mret};
   endfunction

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_word = '0;
      step(); step();
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
      chk_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
      chk_cnt++; if (out_instr !== instr_nop) $display("FAIL reset_out_instr: got %h want %h", out_instr, instr_nop); else pass_cnt++;
      chk_cnt++; if (out_pc !== 32'd0) $display("FAIL reset_out_pc: got %h want 0", out_pc); else pass_cnt++;
      chk_cnt++; if (out_illegal !== 1'b0) $display("FAIL reset_out_illegal: got %b want 0", out_illegal); else pass_cnt++;
      reset = 1'b0;
      step();
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_addi();
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL addi_pre_valid: got %b want 0", out_valid); else pass_cnt++;
      push(32'h100, 32'h00500093);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL addi_latency: got %b want 1", out_valid); else pass_cnt++;
      chk_cnt++; if (out_pc !== 32'h100) $display("FAIL addi_pc: got %h want 00000100", out_pc); else pass_cnt++;
      chk_cnt++; if (out_instr.rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", out_instr.rd); else pass_cnt++;
      chk_cnt++; if (out_instr.rs1 !== 5'd0) $display("FAIL addi_rs1: got %0d want 0", out_instr.rs1); else pass_cnt++;
      chk_cnt++; if (out_instr.imm !== 32'd5) $display("FAIL addi_imm: got %h want 5", out_instr.imm); else pass_cnt++;
      chk_cnt++; if (out_instr.alu_fn !== alu_add) $display("FAIL addi_alu: got %0d want %0d", out_instr.alu_fn, alu_add); else pass_cnt++;
      chk_cnt++; if (flags(out_instr) !== 8'b0110_0000) $display("FAIL addi_flags: got %b want 01100000", flags(out_instr)); else pass_cnt++;
      chk_cnt++; if (count !== 3'd1) $display("FAIL addi_count: got %0d want 1", count); else pass_cnt++;
      pop();
      chk_cnt++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL addi_pop: got valid=%b count=%0d want 0/0", out_valid, count); else pass_cnt++;
   endtask

   task automatic test_sub_branch();
      in_valid = 1'b1; in_pc = 32'h200; in_word = 32'h402081B3;
      step();
      in_pc = 32'h204; in_word = 32'hFE208EE3;
      chk_cnt++; if (out_instr.rd !== 5'd3 || out_instr.rs1 !== 5'd1 || out_instr.rs2 !== 5'd2)
         $display("FAIL sub_regs: got rd=%0d rs1=%0d rs2=%0d want 3/1/2", out_instr.rd, out_instr.rs1, out_instr.rs2); else pass_cnt++;
      chk_cnt++; if (out_instr.alu_fn !== alu_sub) $display("FAIL sub_alu: got %0d want %0d", out_instr.alu_fn, alu_sub); else pass_cnt++;
      chk_cnt++; if (flags(out_instr) !== 8'b0010_0000) $display("FAIL sub_flags: got %b want 00100000", flags(out_instr)); else pass_cnt++;
      chk_cnt++; if (out_instr.imm !== 32'd0) $display("FAIL sub_imm: got %h want 0", out_instr.imm); else pass_cnt++;
      step();
      in_valid = 1'b0;
      chk_cnt++; if (count !== 3'd2) $display("FAIL b2b_count: got %0d want 2", count); else pass_cnt++;
      pop();
      chk_cnt++; if (out_pc !== 32'h204) $display("FAIL branch_pc: got %h want 00000204", out_pc); else pass_cnt++;
      chk_cnt++; if (out_instr.imm !== 32'hFFFFFFFC) $display("FAIL branch_imm: got %h want fffffffc", out_instr.imm); else pass_cnt++;
      chk_cnt++; if (flags(out_instr) !== 8'b1000_0100) $display("FAIL branch_flags: got %b want 10000100", flags(out_instr)); else pass_cnt++;
      chk_cnt++; if (out_instr.alu_fn !== alu_add) $display("FAIL branch_alu: got %0d want %0d", out_instr.alu_fn, alu_add); else pass_cnt++;
      pop();
   endtask

   task automatic test_mret();
      push(32'h300, 32'h30200073);
      chk_cnt++; if (flags(out_instr) !== 8'b0100_0001) $display("FAIL mret_flags: got %b want 01000001", flags(out_instr)); else pass_cnt++;
      chk_cnt++; if (out_instr.alu_fn !== alu_nop) $display("FAIL mret_alu: got %0d want %0d", out_instr.alu_fn, alu_nop); else pass_cnt++;
      chk_cnt++; if (out_illegal !== 1'b0) $display("FAIL mret_illegal: got %b want 0", out_illegal); else pass_cnt++;
      pop();
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_pc = 32'h400 + 32'(4 * i); in_word = 32'h00000093 | (32'(i) << 20);
         step();
      end
      in_pc = 32'h410; in_word = 32'h00400093;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else pass_cnt++;
      step();
      chk_cnt++; if (count !== 3'd4 || out_pc !== 32'h400) $display("FAIL full_hold: got count=%0d pc=%h want 4/00000400", count, out_pc); else pass_cnt++;
      out_ready = 1'b1;
      step();
      chk_cnt++; if (count !== 3'd3 || in_ready !== 1'b1) $display("FAIL drain_first: got count=%0d in_ready=%b want 3/1", count, in_ready); else pass_cnt++;
      chk_cnt++; if (out_pc !== 32'h404 || out_instr.imm !== 32'd1) $display("FAIL drain_order1: got pc=%h imm=%h want 00000404/1", out_pc, out_instr.imm); else pass_cnt++;
      step();
      in_valid = 1'b0;
      chk_cnt++; if (count !== 3'd3 || out_pc !== 32'h408) $display("FAIL push_pop_count: got count=%0d pc=%h want 3/00000408", count, out_pc); else pass_cnt++;
      step();
      chk_cnt++; if (out_pc !== 32'h40C || out_instr.imm !== 32'd3) $display("FAIL drain_order3: got pc=%h imm=%h want 0000040c/3", out_pc, out_instr.imm); else pass_cnt++;
      step();
      chk_cnt++; if (out_pc !== 32'h410 || out_instr.imm !== 32'd4 || count !== 3'd1)
         $display("FAIL wrap_fifth: got pc=%h imm=%h count=%0d want 00000410/4/1", out_pc, out_instr.imm, count); else pass_cnt++;
      step();
      out_ready = 1'b0;
      chk_cnt++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL drain_empty: got valid=%b count=%0d want 0/0", out_valid, count); else pass_cnt++;
   endtask

   task automatic test_flush();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_pc = 32'h500 + 32'(4 * i); in_word = 32'h00100093;
         step();
      end
      in_pc = 32'h999; in_word = 32'h00700093; flush = 1'b1;
      #1;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else pass_cnt++;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_empty: got count=%0d valid=%b want 0/0", count, out_valid); else pass_cnt++;
      chk_cnt++; if (out_pc !== 32'd0) $display("FAIL flush_out_pc: got %h want 0", out_pc); else pass_cnt++;
      step();
      chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_no_ghost: got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      push(32'h600, 32'h00100093);
      push(32'h604, 32'h00200093);
      reset = 1'b1;
      #1;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL midreset_in_ready: got %b want 0", in_ready); else pass_cnt++;
      step();
      reset = 1'b0;
      chk_cnt++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL midreset_empty: got count=%0d valid=%b want 0/0", count, out_valid); else pass_cnt++;
   endtask

   task automatic test_illegal();
      push(32'h700, 32'h00000000);
      chk_cnt++; if (out_illegal !== ILL_EN) $display("FAIL illegal_zero: got %b want %b", out_illegal, ILL_EN); else pass_cnt++;
      chk_cnt++; if (flags(out_instr) !== 8'd0 || out_instr.alu_fn !== alu_nop)
         $display("FAIL illegal_flags: got %b alu=%0d want 00000000 alu=0", flags(out_instr), out_instr.alu_fn); else pass_cnt++;
      pop();
      push(32'h704, 32'h00003003);
      chk_cnt++; if (out_illegal !== ILL_EN || out_instr.is_load !== 1'b1)
         $display("FAIL illegal_load: got ill=%b load=%b want %b/1", out_illegal, out_instr.is_load, ILL_EN); else pass_cnt++;
      pop();
      push(32'h708, 32'h00100093);
      chk_cnt++; if (out_illegal !== 1'b0) $display("FAIL legal_addi_illegal: got %b want 0", out_illegal); else pass_cnt++;
      pop();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sub_branch();
      test_mret();
      test_fill_drain();
      test_flush();
      test_reset_mid();
      test_illegal();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
